// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI4 write-channel arbiter.
// One-hot FSM state encoding plus AXI field constants and a constant-safe clog2.
package axi_arb_pkg;

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_AW   = 4'b0010,
        S_W    = 4'b0100,
        S_B    = 4'b1000
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] OKAY           = 2'b00;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/axi4_wr_arbiter_if.sv
// AXI4 write-channel bundle; N lanes flattened side by side, lane i at slice i.
// B id/resp are shared by all lanes (broadcast on the requester side).
interface axi4_wr_if #(
    parameter int N      = 1,
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic [N*ID_W-1:0]     awid;
    logic [N*ADDR_W-1:0]   awaddr;
    logic [N*8-1:0]        awlen;
    logic [N*3-1:0]        awsize;
    logic [N*2-1:0]        awburst;
    logic [N-1:0]          awvalid;
    logic [N-1:0]          awready;

    logic [N*DATA_W-1:0]   wdata;
    logic [N*DATA_W/8-1:0] wstrb;
    logic [N-1:0]          wlast;
    logic [N-1:0]          wvalid;
    logic [N-1:0]          wready;

    logic [ID_W-1:0]       bid;
    logic [1:0]            bresp;
    logic [N-1:0]          bvalid;
    logic [N-1:0]          bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid,
        output bready,
        input  awready, wready, bid, bresp, bvalid
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid,
        input  bready,
        output awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/axi4_wr_arbiter_rr_picker.sv
// Round-robin priority: first asserted request at or after ptr, wrapping.
// Purely combinational; the only priority logic in the arbiter.
module rr_picker
    import axi_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    localparam int IDX_W      = clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [IDX_W-1:0]       ptr_i,
    output logic                   any_o,
    output logic [IDX_W-1:0]       idx_o
);

    int cand;

    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        cand  = 0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            cand = (int'(ptr_i) + k) % NUM_MASTERS;
            if (!any_o && req_i[cand]) begin
                any_o = 1'b1;
                idx_o = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/axi4_wr_arbiter.sv
// Shares one AXI4 write master port between NUM_MASTERS requesters, one full
// burst (AW, W beats, B) at a time, round-robin, with a sticky WLAST/AWLEN checker.
module axi4_wr_arbiter
    import axi_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 4,
    localparam int IDX_W         = clog2(NUM_MASTERS)
) (
    input  logic             clk,
    input  logic             reset,
    axi4_wr_if.slave         s_axi,
    axi4_wr_if.master        m_axi,
    output logic             m_axi_awlock,
    output logic [3:0]       m_axi_awcache,
    output logic [2:0]       m_axi_awprot,
    output logic [3:0]       m_axi_awqos,
    output logic [3:0]       m_axi_awregion,
    output logic [IDX_W-1:0] grant,
    output logic             busy,
    output logic             err_len
);

    localparam int STRB_W = AXI_DATA_WIDTH / 8;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0]       beat_cnt_q, beat_cnt_d;
    logic [7:0]       len_q, len_d;
    logic             err_len_q, err_len_d;

    logic             req_any;
    logic [IDX_W-1:0] req_idx;
    logic             aw_hs, w_hs, b_hs;
    logic [7:0]       sel_awlen;
    logic             sel_wlast;

    rr_picker #(.NUM_MASTERS(NUM_MASTERS)) u_picker (
        .req_i (s_axi.awvalid),
        .ptr_i (rr_ptr_q),
        .any_o (req_any),
        .idx_o (req_idx)
    );

    assign sel_awlen = s_axi.awlen[int'(grant_q)*8 +: 8];
    assign sel_wlast = s_axi.wlast[grant_q];

    // Downstream valid/ready are only ever raised in their own state, so these are state-qualified.
    assign aw_hs = m_axi.awvalid[0] & m_axi.awready[0];
    assign w_hs  = m_axi.wvalid[0]  & m_axi.wready[0];
    assign b_hs  = m_axi.bvalid[0]  & m_axi.bready[0];

    assign m_axi_awlock   = 1'b0;
    assign m_axi_awcache  = 4'd0;
    assign m_axi_awprot   = 3'd0;
    assign m_axi_awqos    = 4'd0;
    assign m_axi_awregion = 4'd0;

    assign grant   = grant_q;
    assign busy    = (state_q != S_IDLE);
    assign err_len = err_len_q;

    // Channel routing: data fields always follow the grant, handshakes are state-gated.
    always_comb begin
        m_axi.awid    = s_axi.awid[int'(grant_q)*AXI_ID_WIDTH +: AXI_ID_WIDTH];
        m_axi.awaddr  = s_axi.awaddr[int'(grant_q)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        m_axi.awlen   = sel_awlen;
        m_axi.awsize  = s_axi.awsize[int'(grant_q)*3 +: 3];
        m_axi.awburst = s_axi.awburst[int'(grant_q)*2 +: 2];
        m_axi.wdata   = s_axi.wdata[int'(grant_q)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
        m_axi.wstrb   = s_axi.wstrb[int'(grant_q)*STRB_W +: STRB_W];
        m_axi.wlast   = sel_wlast;
        m_axi.awvalid = 1'b0;
        m_axi.wvalid  = 1'b0;
        m_axi.bready  = 1'b0;
        s_axi.awready = '0;
        s_axi.wready  = '0;
        s_axi.bvalid  = '0;
        s_axi.bid     = m_axi.bid;
        s_axi.bresp   = m_axi.bresp;
        unique case (state_q)
            S_AW: begin
                m_axi.awvalid          = s_axi.awvalid[grant_q];
                s_axi.awready[grant_q] = m_axi.awready[0];
            end
            S_W: begin
                m_axi.wvalid          = s_axi.wvalid[grant_q];
                s_axi.wready[grant_q] = m_axi.wready[0];
            end
            S_B: begin
                m_axi.bready          = s_axi.bready[grant_q];
                s_axi.bvalid[grant_q] = m_axi.bvalid[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        len_d      = len_q;
        err_len_d  = err_len_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    grant_d = req_idx;
                    state_d = S_AW;
                end
            end
            S_AW: begin
                if (aw_hs) begin
                    beat_cnt_d = '0;
                    len_d      = sel_awlen;
                    state_d    = S_W;
                end
            end
            S_W: begin
                if (w_hs) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    // Early WLAST and missing WLAST both flag; only WLAST ends the burst.
                    if (sel_wlast) begin
                        if (beat_cnt_q != len_q) err_len_d = 1'b1;
                        state_d = S_B;
                    end else if (beat_cnt_q == len_q) begin
                        err_len_d = 1'b1;
                    end
                end
            end
            S_B: begin
                if (b_hs) begin
                    rr_ptr_d = (grant_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : grant_q + IDX_W'(1);
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            len_q      <= '0;
            err_len_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            len_q      <= len_d;
            err_len_q  <= err_len_d;
        end
    end

endmodule
